// File: rtl/neuron_accum_ctrl.sv
// Bias-plus-terms accumulation sequencer around a shared signed adder.
// Optional saturation on overflow is enabled by defining ACCUM_SAT_EN.

module adder #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

module neuron_accum_ctrl #(
  parameter int WIDTH     = 16,
  parameter int NUM_TERMS = 784,
  parameter int CNT_W     = $clog2(NUM_TERMS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] bias,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  state_t                  state;
  logic signed [WIDTH-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;
  logic signed [WIDTH-1:0] sum;
  logic signed [WIDTH-1:0] acc_next;
  logic                    ovf_next;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a   (acc),
    .b   (in_data),
    .sum (sum)
  );

`ifdef ACCUM_SAT_EN
  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic ovf_now;

  // Same-sign operands producing an opposite-sign sum clamp toward the operand sign.
  always_comb begin
    ovf_now  = (acc[WIDTH-1] == in_data[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
    acc_next = sum;
    if (ovf_now) begin
      acc_next = acc[WIDTH-1] ? MIN_VAL : MAX_VAL;
    end
    ovf_next = ovf | ovf_now;
  end
`else
  // Without saturation ovf is only ever cleared, so it stays at 0.
  assign acc_next = sum;
  assign ovf_next = ovf;
`endif

  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= bias;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf_next;
            // Result registers load once so they stay stable through DONE and IDLE.
            if (cnt == LAST_CNT) begin
              out_data <= acc_next;
              out_ovf  <= ovf_next;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
